mux4_arb: RTL and testbench
===========================

MUX4_ARB -- requirements
Module: mux4_arb

Interface
REQ-001 Parameter QUANTUM, default 4: maximum consecutive grant cycles per owner while others wait; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req  input  4  request from requester i on req[i]; level-sensitive.
REQ-005 d  input  4  data bit of requester i on d[i]; fed to mux4 data inputs d0..d3.
REQ-006 gnt  output  4  one-hot grant; registered.
REQ-007 sel  output  2  mux4 select, encoded index of current/last owner; registered.
REQ-008 busy  output  1  high while any grant is active.
REQ-009 z  output  1  registered copy of d[sel] captured during grant.
REQ-010 z_valid  output  1  high when z holds data captured in the previous grant cycle.

Function
REQ-011 The FSM SHALL have exactly two states: IDLE (no grant) and GRANT (one owner).
REQ-012 In IDLE with req==0, the FSM SHALL stay in IDLE, gnt=0, busy=0.
REQ-013 In IDLE with req!=0, the FSM SHALL enter GRANT next cycle, granting the first set req bit searching ptr, ptr+1, ... mod 4 (1-cycle req->gnt latency).
REQ-014 On every new grant to index i, sel SHALL become i, ptr SHALL become (i+1) mod 4, count SHALL become 0.
REQ-015 In GRANT, count SHALL increment by 1 each cycle the owner is retained, saturating at QUANTUM-1.
REQ-016 In GRANT, if req[owner]==1 and count<QUANTUM-1, the owner SHALL be retained.
REQ-017 In GRANT, if req[owner]==0, the arbiter SHALL grant the next requester (round-robin from ptr) on the next cycle with no idle bubble, or go to IDLE if no other req bit is set.
REQ-018 In GRANT, if count==QUANTUM-1 and any other req bit is set, the arbiter SHALL switch to the next requester in round-robin order on the next cycle.
REQ-019 In GRANT, if count==QUANTUM-1 and no other req bit is set, the owner SHALL be retained and count SHALL reset to 0.
REQ-020 gnt SHALL be one-hot or zero at all times; gnt[sel]==1 whenever busy==1.
REQ-021 busy SHALL equal (state==GRANT).
REQ-022 sel SHALL hold its last value in IDLE.
REQ-023 Each cycle busy==1, z SHALL load d[sel] at the next edge; z SHALL hold otherwise.
REQ-024 z_valid SHALL be busy delayed by one cycle.
REQ-025 Requests on non-owner bits SHALL never preempt the owner before REQ-017/REQ-018 conditions.

Reset
REQ-026 rst SHALL take priority over all other inputs on the same edge.
REQ-027 After a rst edge: state=IDLE, gnt=0, sel=0, busy=0, z=0, z_valid=0, ptr=0, count=0.
REQ-028 rst asserted mid-grant SHALL drop gnt and busy at the next edge; after release, arbitration SHALL restart from ptr=0.

Verification
REQ-029 Reset then req=0001 held -> gnt=0001, sel=0 one cycle later, retained indefinitely (count wraps per REQ-019), busy=1.
REQ-030 QUANTUM=4, req=1111 held from cycle 0 -> gnt 0001 cycles 1-4, 0010 cycles 5-8, 0100 cycles 9-12, 1000 cycles 13-16, 0001 cycle 17.
REQ-031 Owner 0 drops req at cycle 3 with req[2]=1 only -> gnt=0100, sel=2 at cycle 4, no IDLE cycle.
REQ-032 d=4'b1010, grant to 1 at cycle 1 -> z=1, z_valid=1 at cycle 2; grant to 0 later -> z=0 one cycle after that grant.
REQ-033 rst pulsed while gnt=0100 -> next cycle all outputs zero; with req=1111 after release, first grant is 0001.
REQ-034 All req dropped while in GRANT -> IDLE next cycle, gnt=0, busy=0, sel unchanged, z_valid=0 one cycle after busy falls.

Source files
------------

// File: rtl/mux4_arb.sv
// -----------------------------------------------------------------------------
// mux4_arb
//   Four-requester round-robin arbiter driving the select of a 4:1 mux.
//   Each owner keeps the grant for at most QUANTUM consecutive cycles while
//   other requesters wait. The selected data bit is captured into z on every
//   granted cycle.
//
// Parameters
//   QUANTUM  : maximum consecutive grant cycles per owner (1..15)
//
// Ports
//   clk      in   1  clock, all state updates on the rising edge
//   rst      in   1  synchronous active-high reset
//   req      in   4  level-sensitive request, one bit per requester
//   d        in   4  data bit of each requester (mux data inputs d0..d3)
//   gnt      out  4  one-hot grant (registered)
//   sel      out  2  encoded index of current/last owner (registered)
//   busy     out  1  high while a grant is active (registered)
//   z        out  1  registered copy of d[sel] captured during grant
//   z_valid  out  1  busy delayed by one cycle
// -----------------------------------------------------------------------------
module mux4_arb #(
  parameter int unsigned QUANTUM = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] d,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy,
  output logic       z,
  output logic       z_valid
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [3:0] CNT_MAX = 4'(QUANTUM - 1);

  state_t     state_r, state_s;
  logic [3:0] gnt_r, gnt_s;
  logic [1:0] sel_r, sel_s;
  logic [1:0] ptr_r, ptr_s;
  logic [3:0] count_r, count_s;
  logic       busy_r;
  logic       z_r;
  logic       z_valid_r;

  logic [3:0] others_s;
  logic [2:0] pick_any_s;
  logic [2:0] pick_oth_s;

  // Round-robin search: returns {found, index} of the first set bit of mask
  // starting at 'start' and wrapping modulo 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] mask,
                                         input logic [1:0] start);
    logic [1:0] idx;
    rr_pick = 3'b000;
    // Walk from the farthest offset down so the nearest hit is written last.
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (mask[idx]) begin
        rr_pick = {1'b1, idx};
      end else begin
        rr_pick = rr_pick;
      end
    end
  endfunction

  // One-hot decode of a 2-bit index.
  function automatic logic [3:0] onehot(input logic [1:0] idx);
    onehot = 4'b0001 << idx;
  endfunction

  // Candidate selection for both states; the owner is masked out so that a
  // quantum switch never re-selects it.
  always_comb begin
    others_s   = req & ~onehot(sel_r);
    pick_any_s = rr_pick(req, ptr_r);
    pick_oth_s = rr_pick(others_s, ptr_r);
  end

  // Next-state logic: grant, retain, switch or release.
  always_comb begin
    state_s = state_r;
    gnt_s   = gnt_r;
    sel_s   = sel_r;
    ptr_s   = ptr_r;
    count_s = count_r;
    case (state_r)
      IDLE: begin
        if (pick_any_s[2]) begin
          state_s = GRANT;
          gnt_s   = onehot(pick_any_s[1:0]);
          sel_s   = pick_any_s[1:0];
          ptr_s   = pick_any_s[1:0] + 2'd1;
          count_s = 4'd0;
        end else begin
          state_s = IDLE;
          gnt_s   = 4'b0000;
        end
      end
      GRANT: begin
        if (!req[sel_r]) begin
          // Owner released: hand over without a bubble, or fall idle.
          if (pick_oth_s[2]) begin
            gnt_s   = onehot(pick_oth_s[1:0]);
            sel_s   = pick_oth_s[1:0];
            ptr_s   = pick_oth_s[1:0] + 2'd1;
            count_s = 4'd0;
          end else begin
            state_s = IDLE;
            gnt_s   = 4'b0000;
          end
        end else if (count_r < CNT_MAX) begin
          count_s = count_r + 4'd1;
        end else if (pick_oth_s[2]) begin
          // Quantum used up and someone else is waiting.
          gnt_s   = onehot(pick_oth_s[1:0]);
          sel_s   = pick_oth_s[1:0];
          ptr_s   = pick_oth_s[1:0] + 2'd1;
          count_s = 4'd0;
        end else begin
          // Quantum used up but nobody waiting: keep owner, restart quantum.
          count_s = 4'd0;
        end
      end
      default: begin
        state_s = IDLE;
        gnt_s   = 4'b0000;
      end
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      gnt_r   <= 4'b0000;
      sel_r   <= 2'd0;
      ptr_r   <= 2'd0;
      count_r <= 4'd0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      gnt_r   <= gnt_s;
      sel_r   <= sel_s;
      ptr_r   <= ptr_s;
      count_r <= count_s;
      busy_r  <= (state_s == GRANT);
    end
  end

  // Data capture: z samples the muxed bit on every granted cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      z_r       <= 1'b0;
      z_valid_r <= 1'b0;
    end else begin
      z_valid_r <= busy_r;
      if (busy_r) begin
        z_r <= d[sel_r];
      end else begin
        z_r <= z_r;
      end
    end
  end

  assign gnt     = gnt_r;
  assign sel     = sel_r;
  assign busy    = busy_r;
  assign z       = z_r;
  assign z_valid = z_valid_r;

endmodule

// File: tb/tb_mux4_arb.sv
// -----------------------------------------------------------------------------
// tb_mux4_arb
//   Directed-vector bench for mux4_arb (QUANTUM = 4). Stimulus pushes the
//   hand-computed output tuple expected after the next clock edge into a
//   queue; a monitor pops and compares once per edge.
//   Tuple layout: {gnt[3:0], sel[1:0], busy, z, z_valid}.
// -----------------------------------------------------------------------------
module tb_mux4_arb;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] d;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       z;
  logic       z_valid;

  logic [8:0] exp_q[$];
  string      name_q[$];
  int         n_checks;
  int         n_pass;
  bit         stim_done;

  mux4_arb #(.QUANTUM(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .d       (d),
    .gnt     (gnt),
    .sel     (sel),
    .busy    (busy),
    .z       (z),
    .z_valid (z_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue the outputs expected after the edge.
  task automatic step(input string nm, input logic r, input logic [3:0] rq,
                      input logic [3:0] dd, input logic [3:0] eg,
                      input logic [1:0] es, input logic eb, input logic ez,
                      input logic ezv);
    @(negedge clk);
    rst = r;
    req = rq;
    d   = dd;
    exp_q.push_back({eg, es, eb, ez, ezv});
    name_q.push_back(nm);
  endtask

  // Monitor: one comparison per edge for which an expectation is queued.
  always @(posedge clk) begin
    logic [8:0] e;
    logic [8:0] a;
    string      nm;
    #1;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {gnt, sel, busy, z, z_valid};
      n_checks++;
      if (a === e) begin
        n_pass++;
      end else begin
        $display("FAIL %s: got gnt=%b sel=%0d busy=%b z=%b z_valid=%b, want gnt=%b sel=%0d busy=%b z=%b z_valid=%b",
                 nm, a[8:5], a[4:3], a[2], a[1], a[0],
                 e[8:5], e[4:3], e[2], e[1], e[0]);
      end
    end
  end

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    stim_done = 1'b0;
    rst = 1'b1;
    req = 4'b0000;
    d   = 4'b0000;

    // Reset state
    step("reset",     1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    step("idle_noreq",1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);

    // Single requester held: grant after one cycle, retained past quantum
    step("solo_gnt",  1'b0, 4'b0001, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++)
      step("solo_hold", 1'b0, 4'b0001, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b1);
    step("solo_drop", 1'b0, 4'b0000, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b1);
    step("solo_idle", 1'b0, 4'b0000, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0);

    // All four requesting: quantum rotation 0,1,2,3,0
    step("rr_reset",  1'b1, 4'b0000, 4'b1010, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    step("rr_g0_c1",  1'b0, 4'b1111, 4'b1010, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step("rr_g0",   1'b0, 4'b1111, 4'b1010, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b1);
    step("rr_g1_c5",  1'b0, 4'b1111, 4'b1010, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)
      step("rr_g1",   1'b0, 4'b1111, 4'b1010, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b1);
    step("rr_g2_c9",  1'b0, 4'b1111, 4'b1010, 4'b0100, 2'd2, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++)
      step("rr_g2",   1'b0, 4'b1111, 4'b1010, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b1);
    step("rr_g3_c13", 1'b0, 4'b1111, 4'b1010, 4'b1000, 2'd3, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)
      step("rr_g3",   1'b0, 4'b1111, 4'b1010, 4'b1000, 2'd3, 1'b1, 1'b1, 1'b1);
    step("rr_g0_c17", 1'b0, 4'b1111, 4'b1010, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b1);

    // Owner drops with only req[2] pending: direct hand-over, no bubble
    step("drop_rst",  1'b1, 4'b0000, 4'b0100, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    step("drop_g0",   1'b0, 4'b0001, 4'b0100, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0);
    step("drop_hold", 1'b0, 4'b0001, 4'b0100, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b1);
    step("drop_hold", 1'b0, 4'b0001, 4'b0100, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b1);
    step("drop_to2",  1'b0, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b1);
    step("drop_z2",   1'b0, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1, 1'b1);

    // Reset while gnt=0100, then ptr must restart at 0
    step("midrst",    1'b1, 4'b0100, 4'b0100, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    step("midrst_rr", 1'b0, 4'b1111, 4'b0100, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0);

    // Data capture and release to idle with sel held
    step("z_rst",     1'b1, 4'b0000, 4'b1010, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    step("z_g1",      1'b0, 4'b0010, 4'b1010, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0);
    step("z_d1_g0",   1'b0, 4'b0001, 4'b1010, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b1);
    step("z_d0",      1'b0, 4'b0001, 4'b1010, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b1);
    step("z_g2",      1'b0, 4'b0100, 4'b1010, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b1);
    step("z_d2",      1'b0, 4'b0100, 4'b1010, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b1);
    step("rel_idle",  1'b0, 4'b0000, 4'b1010, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b1);
    step("rel_zv0",   1'b0, 4'b0000, 4'b1010, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0);

    // Pointer continues after idle (ptr=3), then quantum wrap 3 -> 0
    step("ptr_g3",    1'b0, 4'b1000, 4'b1010, 4'b1000, 2'd3, 1'b1, 1'b0, 1'b0);
    step("wrap_c1",   1'b0, 4'b1001, 4'b1010, 4'b1000, 2'd3, 1'b1, 1'b1, 1'b1);
    step("wrap_c2",   1'b0, 4'b1001, 4'b1010, 4'b1000, 2'd3, 1'b1, 1'b1, 1'b1);
    step("wrap_c3",   1'b0, 4'b1001, 4'b1010, 4'b1000, 2'd3, 1'b1, 1'b1, 1'b1);
    step("wrap_to0",  1'b0, 4'b1001, 4'b1010, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b1);
    step("wrap_z0",   1'b0, 4'b1001, 4'b1010, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b1);

    stim_done = 1'b1;
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
